pcie_ingress: RTL and testbench

Host-to-device TLP receiver for the Artemis PCIe platform. Sits between the PCIe core's AXI-Stream receive port and the incoming ping-pong FIFO. Parses the 3- or 4-dword TLP header into registered fields and streams payload dwords into the FIFO, re-acquiring FIFO halves when the payload exceeds one half. Finished packets are presented to the controller with a valid/ack handshake.

---
 rtl/pcie_ingress_pkg.sv | 31 +++
 rtl/pcie_tlp_hdr_decode.sv | 23 ++
 rtl/pcie_ingress.sv | 236 +++++++++++++++++++++++
 tb/tb_pcie_ingress.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_ingress_pkg.sv
// Shared TLP field ranges, command codes and ingress state encodings for pcie_ingress.
package pcie_ingress_pkg;

  localparam int TLP_TYPE_MSB  = 31;
  localparam int TLP_TYPE_LSB  = 24;
  localparam int TLP_FLAGS_MSB = 23;
  localparam int TLP_FLAGS_LSB = 10;
  localparam int TLP_LEN_MSB   = 9;
  localparam int TLP_LEN_LSB   = 0;
  localparam int TLP_FMT_4DW   = 29;
  localparam int TLP_FMT_DATA  = 30;

  localparam logic [7:0] MRD_32B = 8'h00;
  localparam logic [7:0] MWR_32B = 8'h40;
  localparam logic [7:0] MWR_64B = 8'h60;
  localparam logic [7:0] CPLD    = 8'h4A;

  typedef enum logic [2:0] {
    IDLE,
    READ_HDR,
    WAIT_FOR_FIFO,
    READ_DATA,
    DISCARD,
    FINISHED
  } ingress_state_e;

  function automatic logic isSupportedData(input logic [7:0] cmd);
    return (cmd == MWR_32B) || (cmd == MWR_64B) || (cmd == CPLD);
  endfunction

endpackage

// File: rtl/pcie_tlp_hdr_decode.sv
// Combinational decode of TLP header dword0: header size, payload presence, length, type support.
module pcie_tlp_hdr_decode
  import pcie_ingress_pkg::*;
(
  input  logic [31:0] dword0_i,
  output logic [2:0]  hdrSize_o,
  output logic        hasData_o,
  output logic [10:0] dwordCnt_o,
  output logic        supported_o
);

  logic [9:0] lenField;
  logic       unusedFlags;

  assign lenField    = dword0_i[TLP_LEN_MSB:TLP_LEN_LSB];
  assign hdrSize_o   = dword0_i[TLP_FMT_4DW] ? 3'd4 : 3'd3;
  assign hasData_o   = dword0_i[TLP_FMT_DATA];
  // A zero length field encodes the maximum of 1024 dwords.
  assign dwordCnt_o  = (lenField == 10'd0) ? 11'd1024 : {1'b0, lenField};
  assign supported_o = isSupportedData(dword0_i[TLP_TYPE_MSB:TLP_TYPE_LSB]);
  assign unusedFlags = ^dword0_i[TLP_FLAGS_MSB:TLP_FLAGS_LSB];

endmodule

// File: rtl/pcie_ingress.sv
// Host-to-device TLP receiver: parses the header and streams payload into the ping-pong FIFO.
// Optional macro PCIE_INGRESS_DISCARD_UNSUPPORTED_EN drains payload of unsupported data TLPs.
module pcie_ingress
  import pcie_ingress_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  output logic        o_pkt_valid,
  input  logic        i_pkt_ack,
  output logic [7:0]  o_command,
  output logic [13:0] o_flags,
  output logic [10:0] o_dword_cnt,
  output logic [31:0] o_hdr1,
  output logic [31:0] o_hdr2,
  output logic [31:0] o_address,
  output logic        o_error,
  input  logic [31:0] i_axi_ingress_data,
  input  logic [3:0]  i_axi_ingress_keep,
  input  logic        i_axi_ingress_last,
  input  logic        i_axi_ingress_valid,
  output logic        o_axi_ingress_ready,
  input  logic        i_fifo_rdy,
  output logic        o_fifo_act,
  input  logic [23:0] i_fifo_size,
  output logic [31:0] o_fifo_data,
  output logic        o_fifo_stb
);

  ingress_state_e state_q;
  logic [2:0]  hdrIdx_q;
  logic [2:0]  hdrSize_q;
  logic        hasData_q;
  logic        supported_q;
  logic [7:0]  command_q;
  logic [13:0] flags_q;
  logic [10:0] dwordCnt_q;
  logic [31:0] hdr1_q;
  logic [31:0] hdr2_q;
  logic [31:0] address_q;
  logic [10:0] dataCount_q;
  logic [23:0] fifoCount_q;
  logic        pktValid_q;
  logic        error_q;
  logic        fifoAct_q;
  logic        fifoStb_q;
  logic [31:0] fifoData_q;

  logic [2:0]  decSize;
  logic        decHasData;
  logic [10:0] decCnt;
  logic        decSupported;
  logic [10:0] dataCount_d;
  logic [23:0] fifoCount_d;
  logic        ready;
  logic        beat;
  logic        finalHdr;
  logic        dataDone;
  logic        fifoFull;
  logic        discardData;
  logic        unusedKeep;

  pcie_tlp_hdr_decode u_hdr_decode (
    .dword0_i    (i_axi_ingress_data),
    .hdrSize_o   (decSize),
    .hasData_o   (decHasData),
    .dwordCnt_o  (decCnt),
    .supported_o (decSupported)
  );

`ifdef PCIE_INGRESS_DISCARD_UNSUPPORTED_EN
  assign discardData = ~supported_q;
`else
  logic unusedSupported;
  assign discardData     = 1'b0;
  assign unusedSupported = supported_q;
`endif

  assign unusedKeep  = ^i_axi_ingress_keep;
  assign dataCount_d = dataCount_q + 11'd1;
  assign fifoCount_d = fifoCount_q + 24'd1;
  assign dataDone    = (dataCount_d == dwordCnt_q);
  assign fifoFull    = (fifoCount_d == i_fifo_size);
  // Header size is only known after dword0, and index 0 can never be the final beat.
  assign finalHdr    = (hdrIdx_q != 3'd0) && (hdrIdx_q == hdrSize_q - 3'd1);
  assign beat        = i_axi_ingress_valid && ready;

  always_comb begin
    ready = 1'b0;
    case (state_q)
      READ_HDR:  ready = 1'b1;
      READ_DATA: ready = (fifoCount_q < i_fifo_size);
      DISCARD:   ready = 1'b1;
      default:   ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hdrIdx_q    <= 3'd0;
      hdrSize_q   <= 3'd0;
      hasData_q   <= 1'b0;
      supported_q <= 1'b0;
      command_q   <= 8'd0;
      flags_q     <= 14'd0;
      dwordCnt_q  <= 11'd0;
      hdr1_q      <= 32'd0;
      hdr2_q      <= 32'd0;
      address_q   <= 32'd0;
      dataCount_q <= 11'd0;
      fifoCount_q <= 24'd0;
      pktValid_q  <= 1'b0;
      error_q     <= 1'b0;
      fifoAct_q   <= 1'b0;
      fifoStb_q   <= 1'b0;
      fifoData_q  <= 32'd0;
    end else begin
      fifoStb_q <= 1'b0;
      case (state_q)
        IDLE: begin
          hdrIdx_q    <= 3'd0;
          dataCount_q <= 11'd0;
          fifoCount_q <= 24'd0;
          if (i_enable) state_q <= READ_HDR;
        end
        READ_HDR: begin
          if (beat) begin
            hdrIdx_q <= hdrIdx_q + 3'd1;
            case (hdrIdx_q)
              3'd0: begin
                command_q   <= i_axi_ingress_data[TLP_TYPE_MSB:TLP_TYPE_LSB];
                flags_q     <= i_axi_ingress_data[TLP_FLAGS_MSB:TLP_FLAGS_LSB];
                dwordCnt_q  <= decCnt;
                hdrSize_q   <= decSize;
                hasData_q   <= decHasData;
                supported_q <= decSupported;
              end
              3'd1: hdr1_q <= i_axi_ingress_data;
              3'd2: begin
                hdr2_q    <= i_axi_ingress_data;
                address_q <= i_axi_ingress_data;
              end
              default: address_q <= i_axi_ingress_data;
            endcase
            if (finalHdr) begin
              if (!hasData_q) begin
                if (i_axi_ingress_last) begin
                  state_q    <= FINISHED;
                  pktValid_q <= 1'b1;
                end else begin
                  error_q <= 1'b1;
                  state_q <= DISCARD;
                end
              end else if (i_axi_ingress_last) begin
                error_q    <= 1'b1;
                state_q    <= FINISHED;
                pktValid_q <= 1'b1;
              end else if (discardData) begin
                state_q <= DISCARD;
              end else begin
                state_q <= WAIT_FOR_FIFO;
              end
            end else if (i_axi_ingress_last) begin
              error_q    <= 1'b1;
              state_q    <= FINISHED;
              pktValid_q <= 1'b1;
            end
          end
        end
        WAIT_FOR_FIFO: begin
          if (i_fifo_rdy && !fifoAct_q) begin
            fifoAct_q   <= 1'b1;
            fifoCount_q <= 24'd0;
            state_q     <= READ_DATA;
          end
        end
        READ_DATA: begin
          if (beat) begin
            fifoData_q  <= i_axi_ingress_data;
            fifoStb_q   <= 1'b1;
            dataCount_q <= dataCount_d;
            fifoCount_q <= fifoCount_d;
            // Completion takes priority, then an early last, then a full FIFO half.
            if (dataDone) begin
              fifoAct_q <= 1'b0;
              if (i_axi_ingress_last) begin
                state_q    <= FINISHED;
                pktValid_q <= 1'b1;
              end else begin
                error_q <= 1'b1;
                state_q <= DISCARD;
              end
            end else if (i_axi_ingress_last) begin
              error_q    <= 1'b1;
              fifoAct_q  <= 1'b0;
              state_q    <= FINISHED;
              pktValid_q <= 1'b1;
            end else if (fifoFull) begin
              fifoAct_q <= 1'b0;
              state_q   <= WAIT_FOR_FIFO;
            end
          end
        end
        DISCARD: begin
          if (beat && i_axi_ingress_last) begin
            state_q    <= FINISHED;
            pktValid_q <= 1'b1;
          end
        end
        FINISHED: begin
          if (i_pkt_ack) begin
            pktValid_q <= 1'b0;
            error_q    <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_axi_ingress_ready = ready;
  assign o_pkt_valid         = pktValid_q;
  assign o_command           = command_q;
  assign o_flags             = flags_q;
  assign o_dword_cnt         = dwordCnt_q;
  assign o_hdr1              = hdr1_q;
  assign o_hdr2              = hdr2_q;
  assign o_address           = address_q;
  assign o_error             = error_q;
  assign o_fifo_act          = fifoAct_q;
  assign o_fifo_data         = fifoData_q;
  assign o_fifo_stb          = fifoStb_q;

endmodule

// File: tb/tb_pcie_ingress.sv
// Scoreboard bench for pcie_ingress: directed TLPs, expected packets and FIFO dwords queued ahead of the DUT.
module tb_pcie_ingress;

  typedef struct {
    logic [7:0]  cmd;
    logic [13:0] flags;
    logic [10:0] cnt;
    logic [31:0] hdr1;
    logic [31:0] hdr2;
    logic [31:0] addr;
    logic        err;
    int          stbs;
    int          acts;
    bit          chkHdr;
  } pkt_t;

  logic        clk;
  logic        rst;
  logic        i_enable;
  logic        o_pkt_valid;
  logic        i_pkt_ack;
  logic [7:0]  o_command;
  logic [13:0] o_flags;
  logic [10:0] o_dword_cnt;
  logic [31:0] o_hdr1;
  logic [31:0] o_hdr2;
  logic [31:0] o_address;
  logic        o_error;
  logic [31:0] i_axi_ingress_data;
  logic [3:0]  i_axi_ingress_keep;
  logic        i_axi_ingress_last;
  logic        i_axi_ingress_valid;
  logic        o_axi_ingress_ready;
  logic        i_fifo_rdy;
  logic        o_fifo_act;
  logic [23:0] i_fifo_size;
  logic [31:0] o_fifo_data;
  logic        o_fifo_stb;

  pkt_t        expPkt[$];
  logic [31:0] expData[$];
  int          checks = 0;
  int          errors = 0;
  int          pktSeen = 0;
  int          stbCount = 0;
  int          actCount = 0;
  bit          dataPhase = 0;

  pcie_ingress dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_enable            (i_enable),
    .o_pkt_valid         (o_pkt_valid),
    .i_pkt_ack           (i_pkt_ack),
    .o_command           (o_command),
    .o_flags             (o_flags),
    .o_dword_cnt         (o_dword_cnt),
    .o_hdr1              (o_hdr1),
    .o_hdr2              (o_hdr2),
    .o_address           (o_address),
    .o_error             (o_error),
    .i_axi_ingress_data  (i_axi_ingress_data),
    .i_axi_ingress_keep  (i_axi_ingress_keep),
    .i_axi_ingress_last  (i_axi_ingress_last),
    .i_axi_ingress_valid (i_axi_ingress_valid),
    .o_axi_ingress_ready (o_axi_ingress_ready),
    .i_fifo_rdy          (i_fifo_rdy),
    .o_fifo_act          (o_fifo_act),
    .i_fifo_size         (i_fifo_size),
    .o_fifo_data         (o_fifo_data),
    .o_fifo_stb          (o_fifo_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input bit l);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    i_axi_ingress_valid = 1'b1;
    i_axi_ingress_data  = d;
    i_axi_ingress_last  = l;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = o_axi_ingress_ready;
      @(posedge clk);
      #1;
      n++;
    end
    i_axi_ingress_valid = 1'b0;
    i_axi_ingress_last  = 1'b0;
    if (!acc) checkOutput("beat_timeout", 32'd0, 32'd1);
  endtask

  task automatic pushPkt(input logic [7:0] cmd, input logic [13:0] flags, input logic [10:0] cnt,
                         input logic [31:0] h1, input logic [31:0] h2, input logic [31:0] addr,
                         input logic err, input int stbs, input int acts, input bit chk);
    pkt_t p;
    p.cmd = cmd; p.flags = flags; p.cnt = cnt; p.hdr1 = h1; p.hdr2 = h2; p.addr = addr;
    p.err = err; p.stbs = stbs; p.acts = acts; p.chkHdr = chk;
    expPkt.push_back(p);
  endtask

  task automatic pushData(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) expData.push_back(base + i);
  endtask

  task automatic runPacket(input logic [31:0] h0, input logic [31:0] h1, input logic [31:0] h2,
                           input logic [31:0] h3, input int nHdr, input int nData, input int lastIdx,
                           input logic [31:0] dataBase, input bit watchWait);
    logic [31:0] hdr[4];
    int target;
    hdr = '{h0, h1, h2, h3};
    target = pktSeen + 1;
    for (int i = 0; i < nHdr + nData; i++) begin
      applyStimulus((i < nHdr) ? hdr[i] : dataBase + 32'(i - nHdr), i == lastIdx);
      if (i == nHdr - 1 && watchWait) dataPhase = 1;
    end
    for (int c = 0; c < 5000 && pktSeen < target; c++) @(posedge clk);
    #1;
    dataPhase = 0;
    if (pktSeen < target) checkOutput("pkt_timeout", 32'd0, 32'd1);
  endtask

  // FIFO model: a half is withheld for two cycles after every release.
  initial begin : fifoModel
    logic prevAct;
    int hold;
    prevAct = 0;
    hold = 0;
    i_fifo_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (prevAct && !o_fifo_act) hold = 2;
      prevAct = o_fifo_act;
      if (hold > 0) begin
        i_fifo_rdy = 1'b0;
        hold--;
      end else begin
        i_fifo_rdy = 1'b1;
      end
    end
  end

  initial begin : monitor
    pkt_t e;
    logic prevAct;
    prevAct = 0;
    i_pkt_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevAct = 0;
      end else begin
        if (o_fifo_act && !prevAct) actCount++;
        prevAct = o_fifo_act;
        if (o_fifo_stb) begin
          stbCount++;
          if (expData.size() == 0) checkOutput("fifo_unexpected_stb", 32'd1, 32'd0);
          else checkOutput("fifo_data", o_fifo_data, expData.pop_front());
        end
        if (dataPhase && !o_fifo_act) checkOutput("ready_in_wait", {31'd0, o_axi_ingress_ready}, 32'd0);
        if (i_pkt_ack) begin
          i_pkt_ack = 1'b0;
        end else if (o_pkt_valid) begin
          if (expPkt.size() == 0) begin
            checkOutput("pkt_unexpected", 32'd1, 32'd0);
          end else begin
            e = expPkt.pop_front();
            if (e.chkHdr) begin
              checkOutput("pkt_command", {24'd0, o_command}, {24'd0, e.cmd});
              checkOutput("pkt_flags", {18'd0, o_flags}, {18'd0, e.flags});
              checkOutput("pkt_dword_cnt", {21'd0, o_dword_cnt}, {21'd0, e.cnt});
              checkOutput("pkt_hdr1", o_hdr1, e.hdr1);
              checkOutput("pkt_hdr2", o_hdr2, e.hdr2);
              checkOutput("pkt_address", o_address, e.addr);
            end
            checkOutput("pkt_error", {31'd0, o_error}, {31'd0, e.err});
            checkOutput("pkt_strobes", 32'(stbCount), 32'(e.stbs));
            checkOutput("pkt_fifo_acts", 32'(actCount), 32'(e.acts));
          end
          stbCount = 0;
          actCount = 0;
          pktSeen++;
          i_pkt_ack = 1'b1;
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1;
    i_enable = 1'b0;
    i_axi_ingress_data = 32'd0;
    i_axi_ingress_keep = 4'hF;
    i_axi_ingress_last = 1'b0;
    i_axi_ingress_valid = 1'b0;
    i_fifo_size = 24'd512;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_pkt_valid", {31'd0, o_pkt_valid}, 32'd0);
    checkOutput("rst_error", {31'd0, o_error}, 32'd0);
    checkOutput("rst_fifo_act", {31'd0, o_fifo_act}, 32'd0);
    checkOutput("rst_fifo_stb", {31'd0, o_fifo_stb}, 32'd0);
    checkOutput("rst_ready", {31'd0, o_axi_ingress_ready}, 32'd0);
    checkOutput("rst_fifo_data", o_fifo_data, 32'd0);
    checkOutput("rst_command", {24'd0, o_command}, 32'd0);
    checkOutput("rst_dword_cnt", {21'd0, o_dword_cnt}, 32'd0);
    checkOutput("rst_address", o_address, 32'd0);
    rst = 1'b0;
    i_enable = 1'b1;

    $display("[TB] MWr32 length 4");
    pushPkt(8'h40, 14'h2AF3, 11'd4, 32'h010000FF, 32'h10000040, 32'h10000040, 1'b0, 4, 1, 1);
    pushData(32'hA0000000, 4);
    runPacket(32'h40ABCC04, 32'h010000FF, 32'h10000040, 32'h0, 3, 4, 6, 32'hA0000000, 1);

    $display("[TB] MRd64");
    pushPkt(8'h20, 14'h0, 11'd1, 32'h0200000F, 32'h00000001, 32'hCAFE0000, 1'b0, 0, 0, 1);
    runPacket(32'h20000001, 32'h0200000F, 32'h00000001, 32'hCAFE0000, 4, 0, 3, 32'h0, 0);

    $display("[TB] MWr32 length 10 through 4-dword FIFO halves");
    i_fifo_size = 24'd4;
    pushPkt(8'h40, 14'h0, 11'd10, 32'h03000010, 32'h20000000, 32'h20000000, 1'b0, 10, 3, 1);
    pushData(32'hB0000000, 10);
    runPacket(32'h4000000A, 32'h03000010, 32'h20000000, 32'h0, 3, 10, 12, 32'hB0000000, 1);
    i_fifo_size = 24'd512;

    $display("[TB] early last on data beat 2 of 8");
    pushPkt(8'h40, 14'h0, 11'd8, 32'h03000011, 32'h20000100, 32'h20000100, 1'b1, 2, 1, 1);
    pushData(32'hC0000000, 2);
    runPacket(32'h40000008, 32'h03000011, 32'h20000100, 32'h0, 3, 2, 4, 32'hC0000000, 1);

    $display("[TB] length field 0");
    pushPkt(8'h40, 14'h0, 11'd1024, 32'h03000012, 32'h20001000, 32'h20001000, 1'b0, 1024, 2, 1);
    pushData(32'hD0000000, 1024);
    runPacket(32'h40000000, 32'h03000012, 32'h20001000, 32'h0, 3, 1024, 1026, 32'hD0000000, 1);

    $display("[TB] unsupported data TLP");
`ifdef PCIE_INGRESS_DISCARD_UNSUPPORTED_EN
    pushPkt(8'h44, 14'h0, 11'd2, 32'h03000013, 32'h20002000, 32'h20002000, 1'b0, 0, 0, 1);
`else
    pushPkt(8'h44, 14'h0, 11'd2, 32'h03000013, 32'h20002000, 32'h20002000, 1'b0, 2, 1, 1);
    pushData(32'hE0000000, 2);
`endif
    runPacket(32'h44000002, 32'h03000013, 32'h20002000, 32'h0, 3, 2, 4, 32'hE0000000, 0);

    $display("[TB] MRd32 missing last drains to DISCARD");
    pushPkt(8'h00, 14'h0, 11'd1, 32'h04000001, 32'h30000000, 32'h30000000, 1'b1, 0, 0, 1);
    runPacket(32'h00000001, 32'h04000001, 32'h30000000, 32'h0, 3, 2, 4, 32'hF0000000, 0);

    $display("[TB] last on header beat 1");
    pushPkt(8'h40, 14'h0, 11'd4, 32'h0, 32'h0, 32'h0, 1'b1, 0, 0, 0);
    runPacket(32'h40000004, 32'h04000002, 32'h0, 32'h0, 2, 0, 1, 32'h0, 0);

    $display("[TB] late last after full payload");
    pushPkt(8'h40, 14'h0, 11'd2, 32'h04000003, 32'h30000100, 32'h30000100, 1'b1, 2, 1, 1);
    pushData(32'h90000000, 2);
    runPacket(32'h40000002, 32'h04000003, 32'h30000100, 32'h0, 3, 3, 5, 32'h90000000, 0);

    $display("[TB] reset mid-packet");
    applyStimulus(32'h60000004, 1'b0);
    applyStimulus(32'h5555AAAA, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_ready", {31'd0, o_axi_ingress_ready}, 32'd0);
    checkOutput("midrst_command", {24'd0, o_command}, 32'd0);
    checkOutput("midrst_hdr1", o_hdr1, 32'd0);
    checkOutput("midrst_pkt_valid", {31'd0, o_pkt_valid}, 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    checkOutput("leftover_pkts", 32'(expPkt.size()), 32'd0);
    checkOutput("leftover_data", 32'(expData.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
